// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART arbiter constants: FSM state encoding and transmitter handshake timeout.
package uart_tx_arbiter_pkg;

    localparam int unsigned TX_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after ptr, wrapping modulo 4.
module uart_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        // k=4 wraps back to ptr itself, so the last grantee has lowest priority
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = ptr + k[1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requests from four sources onto one serial transmitter with lock support.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [8*NREQ-1:0]   data,
    output logic [NREQ-1:0]     ack,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic                err,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_ready
);

    arb_state_t state, state_next;
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] win_idx;
    logic       go;
    logic       timeout;
    logic [2:0] to_cnt;
    logic       lock_hold;

    uart_rr_pick u_rr_pick (
        .req   (req),
        .ptr   (grant_id),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        go         = 1'b0;
        timeout    = 1'b0;
        // A held lock only wins while its owner still requests; otherwise fall back to round-robin
        win_idx    = (lock_hold && req[grant_id]) ? grant_id : pick_idx;
        unique case (state)
            IDLE: begin
                if (tx_ready && pick_valid) begin
                    go         = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_next = WAIT_DONE;
                end else if (to_cnt == 3'(TX_TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_start  <= 1'b0;
            tx_data   <= '0;
            ack       <= '0;
            err       <= 1'b0;
            grant_id  <= 2'd3;
            lock_hold <= 1'b0;
            to_cnt    <= '0;
        end else begin
            tx_start <= go;
            ack      <= go ? (NREQ'(1) << win_idx) : '0;
            err      <= timeout;
            to_cnt   <= (state == WAIT_BUSY) ? 3'(to_cnt + 3'd1) : '0;
            if (go) begin
                grant_id  <= win_idx;
                tx_data   <= data[{win_idx, 3'b000} +: 8];
                lock_hold <= lock[win_idx];
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester/transmitter models plus a decoupled monitor.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req, lock, ack;
    logic [31:0] data;
    logic [1:0]  grant_id;
    logic        busy, err, tx_start, tx_ready;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .lock     (lock),
        .data     (data),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    typedef struct { logic [7:0] b; logic l; } item_t;
    typedef struct { logic [1:0] id; logic [7:0] b; } exp_t;

    item_t rq [4][$];
    exp_t  expq [$];

    int   total = 0, bad = 0;
    int   cyc = 0, last_start = 0;
    int   acks_seen = 0, starts_seen = 0, err_expected = 0;
    logic tx_stuck = 1'b0, tx_force_busy = 1'b0;
    logic [7:0] cur_byte = '0;
    logic cur_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] b, input logic l);
        item_t it;
        it.b = b;
        it.l = l;
        rq[i].push_back(it);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.b  = b;
        expq.push_back(e);
    endtask

    function automatic int pending();
        return rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size();
    endfunction

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (!busy && expq.size() == 0 && pending() == 0) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: idle timeout busy=%0d pending=%0d expected busy=0 pending=0", name, busy, pending());
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"},  tx_data, 0);
        check({tag, "_ack"},      ack, 0);
        check({tag, "_err"},      err, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_grant_id"}, grant_id, 3);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: consume one byte per ack, present the next one from the queue
    initial begin
        req = '0; lock = '0; data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            for (int i = 0; i < 4; i++) begin
                req[i]          = (rq[i].size() > 0);
                lock[i]         = req[i] ? rq[i][0].l : 1'b0;
                data[8*i +: 8]  = req[i] ? rq[i][0].b : 8'h00;
            end
        end
    end

    // Transmitter: busy for three cycles after each start unless stuck ready or forced busy
    initial begin
        int busy_left;
        busy_left = 0;
        tx_ready  = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) busy_left = 0;
            else if (tx_start && !tx_stuck) busy_left = 3;
            if (tx_force_busy) tx_ready = 1'b0;
            else if (busy_left > 0) begin
                tx_ready = 1'b0;
                busy_left--;
            end else tx_ready = 1'b1;
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (tx_start) begin
                starts_seen++;
                last_start = cyc;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got id=%0d byte=%0h expected no start", grant_id, tx_data);
                end else begin
                    e = expq.pop_front();
                    check("grant_id", grant_id, e.id);
                    check("tx_data", tx_data, e.b);
                    check("ack_onehot", ack, 32'd1 << e.id);
                    cur_byte  = e.b;
                    cur_valid = 1'b1;
                end
            end else if (ack != '0) begin
                check("ack_without_start", ack, 0);
            end
            if (ack != '0) acks_seen++;
            if (busy && cur_valid && !tx_start) check("tx_data_stable", tx_data, cur_byte);
            if (!busy) cur_valid = 1'b0;
            if (err) begin
                if (err_expected > 0) begin
                    err_expected--;
                    check("err_delay", cyc - last_start, 5);
                end else check("err_spurious", err, 0);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 rstn = 1'b1;

        // Single byte from requester 0, with latency check
        @(posedge clk); #1;
        push_byte(0, 8'h55, 1'b0);
        push_exp(2'd0, 8'h55);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk); #1;
                if (req != '0) seen = 1'b1;
            end
            check("req_applied", seen, 1);
        end
        @(negedge clk);
        check("latency_tx_start", tx_start, 1);
        check("latency_ack", ack, 4'b0001);
        wait_idle("single");
        check("single_idle_busy", busy, 0);

        @(posedge clk); #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_grant_id", grant_id, 3);
        @(posedge clk); #1 rstn = 1'b1;

        // Fairness: all four requesting, requester 0 has a second byte
        @(posedge clk); #1;
        push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b0);
        push_byte(1, 8'hB1, 1'b0); push_byte(2, 8'hC2, 1'b0); push_byte(3, 8'hD3, 1'b0);
        push_exp(2'd0, 8'hA0); push_exp(2'd1, 8'hB1); push_exp(2'd2, 8'hC2);
        push_exp(2'd3, 8'hD3); push_exp(2'd0, 8'hA1);
        wait_idle("fairness");
        check("fairness_acks", acks_seen, 6);

        // Lock: requester 1 sends a 3-byte message ahead of requester 0
        @(posedge clk); #1;
        push_byte(1, 8'h11, 1'b1); push_byte(1, 8'h12, 1'b1); push_byte(1, 8'h13, 1'b0);
        push_byte(0, 8'h01, 1'b0);
        push_exp(2'd1, 8'h11); push_exp(2'd1, 8'h12); push_exp(2'd1, 8'h13); push_exp(2'd0, 8'h01);
        wait_idle("lock");

        // Timeout: transmitter never drops ready
        @(posedge clk); #1;
        tx_stuck = 1'b1;
        err_expected = 1;
        push_byte(2, 8'h77, 1'b0);
        push_exp(2'd2, 8'h77);
        wait_idle("timeout");
        check("timeout_err_seen", err_expected, 0);
        check("timeout_idle", busy, 0);
        tx_stuck = 1'b0;

        // Busy transmitter blocks granting
        @(posedge clk); #1;
        tx_force_busy = 1'b1;
        push_byte(2, 8'h44, 1'b0);
        push_exp(2'd2, 8'h44);
        repeat (6) begin
            @(negedge clk); #1;
            check("blocked_no_ack", ack, 0);
        end
        check("blocked_not_busy", busy, 0);
        @(posedge clk); #1 tx_force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("grant_after_ready", tx_start, 1);
        wait_idle("blocking");

        // Reset while in WAIT_DONE, then a normal grant to requester 3
        @(posedge clk); #1;
        push_byte(1, 8'h99, 1'b0);
        push_exp(2'd1, 8'h99);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk); #1;
                if (tx_start) seen = 1'b1;
            end
            check("wd_start_seen", seen, 1);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_values("wd_reset");
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        push_byte(3, 8'h88, 1'b0);
        push_exp(2'd3, 8'h88);
        wait_idle("after_reset");
        check("after_reset_grant_id", grant_id, 3);

        check("total_starts", starts_seen, 14);
        check("total_acks", acks_seen, 14);
        check("scoreboard_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
